// File: rtl/train_sample_sequencer_pkg.sv
// Shared types and defaults for the training-sample sequencer.
// Holds the engine FSM encoding, geometry defaults and the Q8.8 pixel format.
package train_sample_sequencer_pkg;

    localparam int NUM_PIXELS_DEF = 784;
    localparam int ADDR_W_DEF     = 10;
    localparam int PIX_INT_W      = 8;
    localparam int PIX_FRAC_W     = 8;
    localparam int PIX_W          = PIX_INT_W + PIX_FRAC_W;
    localparam int LABEL_W        = 8;

    typedef enum logic [1:0] {
        E_IDLE,
        E_START,
        E_WAIT,
        E_SCORE
    } eng_state_e;

    typedef struct packed {
        logic [LABEL_W-1:0] label;
        logic               train;
    } side_t;

endpackage

// File: rtl/sample_bank_ram.sv
// One sample bank: single write port, registered read port, 16-bit words.
// Latency: read data valid one cycle after rd_addr. No backpressure.
module sample_bank_ram
    import train_sample_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_dat
);

    logic [PIX_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/train_sample_sequencer.sv
// Streams pixels into sample banks, hands full banks to the engine, scores results (SEQ_DOUBLE_BUFFER_EN: two banks).
// Latency: engine start one cycle after bank full; counters and sample_done update the cycle after scoring.
// Backpressure: pix_ready drops while the bank being loaded is still full.
module train_sample_sequencer
    import train_sample_sequencer_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic [LABEL_W-1:0] pix_label,
    input  logic               train_en,
    output logic               eng_start,
    output logic               eng_train,
    input  logic               eng_done,
    input  logic [LABEL_W-1:0] eng_output_idx,
    input  logic [ADDR_W-1:0]  eng_mem_address,
    output logic [PIX_W-1:0]   eng_mem_input,
    output logic [LABEL_W-1:0] eng_expected_out,
    output logic [CNT_W-1:0]   acc_correct,
    output logic [CNT_W-1:0]   acc_total,
    input  logic               acc_clear,
    output logic               sample_done
);

`ifdef SEQ_DOUBLE_BUFFER_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic              run_q;
    logic [ADDR_W-1:0] load_cnt;
    logic              load_ptr;
    logic              eng_ptr;
    logic [NB-1:0]     full;
    side_t             side [NB];
    logic [PIX_W-1:0]  rd_dat [NB];
    eng_state_e        state, state_nx;
    logic              done_q;
    logic              eng_clr;
    logic              pix_acc;
    logic              load_set;
    logic              hit;

    assign pix_ready = run_q && !reset && !full[load_ptr];
    assign pix_acc   = pix_valid && pix_ready;
    assign load_set  = pix_acc && (load_cnt == ADDR_W'(NUM_PIXELS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q    <= 1'b0;
            load_cnt <= '0;
        end else begin
            run_q <= 1'b1;
            if (load_set) begin
                load_cnt <= '0;
            end else if (pix_acc) begin
                load_cnt <= load_cnt + ADDR_W'(1);
            end
        end
    end

    // Label/train flag travel with the bank, captured on the first pixel only.
    always_ff @(posedge clock) begin
        if (pix_acc && load_cnt == '0) begin
            side[load_ptr] <= '{label: pix_label, train: train_en};
        end
    end

`ifdef SEQ_DOUBLE_BUFFER_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            load_ptr <= 1'b0;
            eng_ptr  <= 1'b0;
        end else begin
            if (load_set) load_ptr <= ~load_ptr;
            if (eng_clr)  eng_ptr  <= ~eng_ptr;
        end
    end
`else
    assign load_ptr = 1'b0;
    assign eng_ptr  = 1'b0;
`endif

    // Set and clear target different banks when they coincide, so both land.
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (load_set && load_ptr == 1'(b)) full[b] <= 1'b1;
                if (eng_clr && eng_ptr == 1'(b))   full[b] <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_bank
        sample_bank_ram #(.ADDR_W(ADDR_W)) u_ram (
            .clock   (clock),
            .wr_en   (pix_acc && load_ptr == 1'(g)),
            .wr_addr (load_cnt),
            .wr_dat  (pix_data),
            .rd_addr (eng_mem_address),
            .rd_dat  (rd_dat[g])
        );
    end

    assign eng_mem_input    = rd_dat[eng_ptr];
    assign eng_train        = side[eng_ptr].train;
    assign eng_expected_out = side[eng_ptr].label;
    assign hit              = (eng_output_idx == side[eng_ptr].label);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= E_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= eng_done;
        end
    end

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        eng_clr   = 1'b0;
        case (state)
            // Wait for a lingering done from the previous sample to drop.
            E_IDLE:  if (full[eng_ptr] && !eng_done) state_nx = E_START;
            E_START: begin
                eng_start = 1'b1;
                state_nx  = E_WAIT;
            end
            E_WAIT:  if (eng_done && !done_q) state_nx = E_SCORE;
            E_SCORE: begin
                eng_clr  = 1'b1;
                state_nx = E_IDLE;
            end
            default: state_nx = E_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_correct <= '0;
            acc_total   <= '0;
            sample_done <= 1'b0;
        end else begin
            sample_done <= eng_clr;
            if (acc_clear) begin
                acc_total   <= eng_clr ? CNT_W'(1) : '0;
                acc_correct <= (eng_clr && hit) ? CNT_W'(1) : '0;
            end else if (eng_clr && acc_total != {CNT_W{1'b1}}) begin
                acc_total <= acc_total + CNT_W'(1);
                if (hit) acc_correct <= acc_correct + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_train_sample_sequencer.sv
// Randomized scoreboard bench for train_sample_sequencer with a behavioural engine model.
// Works with or without SEQ_DOUBLE_BUFFER_EN.
module tb_train_sample_sequencer;

    localparam int NP   = 784;
    localparam int AW   = 10;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock, reset;
    logic          pix_valid, pix_ready, train_en;
    logic [15:0]   pix_data;
    logic [7:0]    pix_label;
    logic          eng_start, eng_train, eng_done;
    logic [7:0]    eng_output_idx, eng_expected_out;
    logic [AW-1:0] eng_mem_address;
    logic [15:0]   eng_mem_input;
    logic [CW-1:0] acc_correct, acc_total;
    logic          acc_clear, sample_done;
    logic          clr_main, clr_eng;

    assign acc_clear = clr_main | clr_eng;

    train_sample_sequencer #(.NUM_PIXELS(NP), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_label(pix_label), .train_en(train_en),
        .eng_start(eng_start), .eng_train(eng_train), .eng_done(eng_done),
        .eng_output_idx(eng_output_idx), .eng_mem_address(eng_mem_address),
        .eng_mem_input(eng_mem_input), .eng_expected_out(eng_expected_out),
        .acc_correct(acc_correct), .acc_total(acc_total),
        .acc_clear(acc_clear), .sample_done(sample_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int label;
        bit train;
        int idx;
        int lat;
        int hold;
        bit clr;
        int slot;
    } job_t;

    typedef struct {
        int correct;
        int total;
    } cnt_t;

    job_t        job_q[$];
    cnt_t        score_q[$];
    logic [15:0] pix_store [4][NP];
    int vectors = 0, errors = 0;
    int m_correct = 0, m_total = 0;
    int n_loaded = 0, n_scored = 0, n_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Loads npix pixels; only a complete sample is handed to the engine model.
    task automatic load_sample(input int label, input bit train, input int idx, input int lat,
                               input int hold, input bit clr, input int max_gap, input int npix,
                               output int stalls);
        int slot;
        int i;
        int budget;
        int bad;
        bit acc;
        job_t j;
        slot   = n_loaded % 4;
        i      = 0;
        budget = 0;
        stalls = 0;
        @(posedge clock); #1;
        while (i < npix && budget < 20000) begin
            repeat ($urandom_range(max_gap, 0)) begin
                pix_valid = 1'b0;
                @(posedge clock); #1;
            end
            pix_valid = 1'b1;
            pix_data  = 16'($urandom);
            pix_label = (i == 0) ? 8'(label) : 8'($urandom);
            train_en  = (i == 0) ? train : 1'($urandom);
            @(negedge clock);
            acc = pix_ready;
            @(posedge clock); #1;
            budget++;
            if (acc) begin
                pix_store[slot][i] = pix_data;
                i++;
            end else begin
                stalls++;
            end
        end
        pix_valid = 1'b0;
        if (i < npix) check("load_timeout", i, npix);
        if (npix == NP) begin
            j = '{label: label, train: train, idx: idx, lat: lat, hold: hold, clr: clr, slot: slot};
            job_q.push_back(j);
            n_loaded++;
`ifndef SEQ_DOUBLE_BUFFER_EN
            bad = 0;
            budget = 0;
            forever begin
                @(negedge clock);
                budget++;
                if (sample_done === 1'b1) break;
                if (pix_ready !== 1'b0) bad++;
                if (budget > 5000) break;
            end
            check("ready_low_while_full", bad, 0);
            check("ready_high_at_score", pix_ready, 1);
`endif
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (n_scored < n_loaded && t < 5000) begin
            @(negedge clock);
            t++;
        end
        check("idle_scored", n_scored, n_loaded);
    endtask

    // Engine model: checks sideband and RAM readback, returns a result after lat cycles.
    task automatic run_job(input job_t j);
        int a;
        check("expected_out", eng_expected_out, j.label);
        check("eng_train", eng_train, 32'(j.train));
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(NP - 1, 0);
            eng_mem_address = AW'(a);
            @(posedge clock);
            @(negedge clock);
            if (k == 0) check("start_one_cycle", eng_start, 0);
            check("mem_read", eng_mem_input, pix_store[j.slot][a]);
        end
        repeat (j.lat) @(posedge clock);
        #1;
        eng_output_idx = 8'(j.idx);
        eng_done = 1'b1;
        if (j.clr) begin
            m_total   = 1;
            m_correct = (j.idx == j.label) ? 1 : 0;
        end else if (m_total < CMAX) begin
            m_total++;
            if (j.idx == j.label) m_correct++;
        end
        score_q.push_back('{correct: m_correct, total: m_total});
        for (int c = 1; c <= 3; c++) begin
            @(posedge clock); #1;
            clr_eng = (c == 1) && j.clr;
            if (c == 2) check("sideband_stable", eng_expected_out, j.label);
            if (c >= j.hold) eng_done = 1'b0;
        end
    endtask

    initial begin
        job_t j;
        eng_done = 1'b0;
        eng_output_idx = '0;
        eng_mem_address = '0;
        clr_eng = 1'b0;
        forever begin
            @(negedge clock);
            if (eng_start === 1'b1) begin
                if (job_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    j = job_q.pop_front();
                    run_job(j);
                end
            end
        end
    end

    always @(negedge clock) begin
        cnt_t e;
        if (eng_start === 1'b1) begin
            n_start++;
            check("start_while_done", eng_done, 0);
        end
        if (sample_done === 1'b1) begin
            n_scored++;
            if (score_q.size() == 0) begin
                check("unexpected_score", 1, 0);
            end else begin
                e = score_q.pop_front();
                check("acc_correct", acc_correct, e.correct);
                check("acc_total", acc_total, e.total);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int st, tot_st, lbl, idx;
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_data = '0;
        pix_label = '0;
        train_en = 1'b0;
        clr_main = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_sample_done", sample_done, 0);
        check("rst_acc_correct", acc_correct, 0);
        check("rst_acc_total", acc_total, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("ready_after_reset", pix_ready, 1);

        // Single sample, label 3, engine answers 3 after 50 cycles.
        load_sample(3, 1'b1, 3, 50, 1, 1'b0, 0, NP, st);
        wait_idle();
        check("first_starts", n_start, 1);
        check("first_correct", acc_correct, 1);
        check("first_total", acc_total, 1);

        // Reset part-way through a load: nothing scored, next sample starts at address 0.
        load_sample(9, 1'b0, 9, 10, 1, 1'b0, 0, 400, st);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("midload_rst_ready", pix_ready, 0);
        check("midload_rst_total", acc_total, 0);
        m_correct = 0;
        m_total = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (100) @(posedge clock);
        check("no_start_after_reset", n_start, 1);
        load_sample(5, 1'b0, 5, 20, 2, 1'b0, 1, NP, st);
        wait_idle();
        check("after_reset_total", acc_total, 1);

        // Back-to-back samples with continuous pix_valid; long done holds mixed in.
        tot_st = 0;
        for (int s = 0; s < 5; s++) begin
            lbl = $urandom_range(9, 0);
            idx = ($urandom_range(1, 0) == 1) ? lbl : int'($urandom_range(255, 0));
            load_sample(lbl, 1'($urandom), idx, $urandom_range(60, 5),
                        (s == 0) ? 3 : $urandom_range(3, 1), 1'b0, 0, NP, st);
            tot_st += st;
        end
`ifdef SEQ_DOUBLE_BUFFER_EN
        check("b2b_no_stall", tot_st, 0);
`endif
        wait_idle();

        for (int s = 0; s < 3; s++) begin
            lbl = $urandom_range(9, 0);
            idx = ($urandom_range(1, 0) == 1) ? lbl : int'($urandom_range(255, 0));
            load_sample(lbl, 1'($urandom), idx, $urandom_range(40, 5),
                        $urandom_range(3, 1), 1'b0, 2, NP, st);
        end
        wait_idle();
        check("total_saturated", acc_total, CMAX);

        // acc_clear landing on the scoring cycle: cleared, then this sample counted.
        load_sample(7, 1'b1, 7, 15, 3, 1'b1, 0, NP, st);
        wait_idle();
        check("clear_with_score_total", acc_total, 1);
        check("clear_with_score_correct", acc_correct, 1);

        @(posedge clock); #1;
        clr_main = 1'b1;
        @(posedge clock); #1;
        clr_main = 1'b0;
        @(negedge clock);
        check("clear_total", acc_total, 0);
        check("clear_correct", acc_correct, 0);
        m_correct = 0;
        m_total = 0;

        repeat (20) @(posedge clock);
        check("start_count", n_start, n_loaded);
        check("jobs_drained", job_q.size(), 0);
        check("scores_drained", score_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
